mont_mul_arbiter: RTL and testbench

- Shares one pipelined Montgomery multiplier (single-beat AXI-stream, operands {b,a} in, reduced product out) between NUM_REQ independent requesters.
- Round-robin arbitration; requester ID appended above the ctl field; returned results routed back by that ID.
- Credit counter caps in-flight operations at MAX_OUTSTANDING so the multiplier's internal input FIFO never overflows.
- Sits between the field-arithmetic engines (point add/double, Fp2 towers) and the multiplier instance.

---
 rtl/mont_mul_arb_pkg.sv | 21 ++
 rtl/mont_mul_arbiter_rr_arbiter.sv | 46 ++++
 rtl/mont_mul_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mont_mul_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_arb_pkg.sv
// Shared helpers and types for the Montgomery-multiplier sharing fabric.
package mont_mul_arb_pkg;

  function automatic int credit_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  // A single requester still needs a 1-bit tag field so the ctl layout stays uniform.
  function automatic int id_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_CTL_BITS = 8;

  typedef struct packed {
    logic [id_w(DEF_NUM_REQ)-1:0] id;
    logic [DEF_CTL_BITS-1:0]      ctl;
  } tag_ctl_t;

endpackage

// File: rtl/mont_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or above the pointer wins, pointer moves past the winner.
module rr_arbiter
  import mont_mul_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = id_w(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Outer loop walks priority order, inner loop keeps every vector index constant.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!any_o && req_i[r] && (((int'(ptr_q) + i) % NUM_REQ) == r)) begin
          any_o    = 1'b1;
          gnt_o[r] = 1'b1;
          idx_o    = IDX_W'(r);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && any_o)
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one pipelined Montgomery multiplier between NUM_REQ requesters with
// round-robin issue, credit-limited occupancy and id-routed results.
module mont_mul_arbiter
  import mont_mul_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int DAT_BITS        = 381,
  parameter  int CTL_BITS        = 8,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int ID_BITS         = id_w(NUM_REQ),
  localparam int CRED_W          = credit_w(MAX_OUTSTANDING)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_val,
  input  logic [NUM_REQ*2*DAT_BITS-1:0] i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]   i_req_ctl,
  output logic [NUM_REQ-1:0]            o_req_rdy,
  output logic                          o_mul_val,
  output logic [2*DAT_BITS-1:0]         o_mul_dat,
  output logic [CTL_BITS+ID_BITS-1:0]   o_mul_ctl,
  input  logic                          i_mul_rdy,
  input  logic                          i_mul_val,
  input  logic [DAT_BITS-1:0]           i_mul_dat,
  input  logic [CTL_BITS+ID_BITS-1:0]   i_mul_ctl,
  output logic                          o_mul_rdy,
  output logic [NUM_REQ-1:0]            o_rsp_val,
  output logic [NUM_REQ*DAT_BITS-1:0]   o_rsp_dat,
  output logic [NUM_REQ*CTL_BITS-1:0]   o_rsp_ctl,
  input  logic [NUM_REQ-1:0]            i_rsp_rdy,
  output logic [CRED_W-1:0]             o_credits,
  output logic                          o_err_id
);

  typedef struct packed {
    logic [ID_BITS-1:0]  id;
    logic [CTL_BITS-1:0] ctl;
  } tag_t;

  logic [NUM_REQ-1:0][2*DAT_BITS-1:0] req_dat;
  logic [NUM_REQ-1:0][CTL_BITS-1:0]   req_ctl;
  assign req_dat = i_req_dat;
  assign req_ctl = i_req_ctl;

  // ---------------- issue side ----------------
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_BITS-1:0]    win_idx;
  logic                  win_any;
  logic                  slot_free, grant_ok, accept;
  logic                  mul_val_q, mul_val_d;
  logic [2*DAT_BITS-1:0] mul_dat_q, sel_dat;
  tag_t                  mul_tag_q, sel_tag;
  logic [CRED_W-1:0]     cred_q, cred_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req_i (i_req_val),
    .adv_i (accept),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign slot_free = ~mul_val_q | i_mul_rdy;
  assign grant_ok  = ~i_rst & slot_free & (cred_q != '0);
  assign accept    = grant_ok & win_any;
  assign o_req_rdy = grant_ok ? gnt : '0;

  always_comb begin
    sel_dat     = '0;
    sel_tag     = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        sel_dat     = req_dat[r];
        sel_tag.ctl = req_ctl[r];
      end
    end
    sel_tag.id = win_idx;
  end

  assign mul_val_d = accept | (mul_val_q & ~i_mul_rdy);

  // ---------------- return side ----------------
  logic [ID_BITS-1:0]               ret_id;
  logic [NUM_REQ-1:0]               hit, lane_free, rsp_ld;
  logic [NUM_REQ-1:0]               rsp_val_q, rsp_val_d;
  logic [NUM_REQ-1:0][DAT_BITS-1:0] rsp_dat_q;
  logic [NUM_REQ-1:0][CTL_BITS-1:0] rsp_ctl_q;
  logic                             id_ok, ret, ovf;
  logic                             err_q, err_d;

  assign ret_id = i_mul_ctl[CTL_BITS +: ID_BITS];

  always_comb begin
    hit = '0;
    for (int r = 0; r < NUM_REQ; r++)
      hit[r] = (ret_id == ID_BITS'(r));
  end

  // Unknown ids are always accepted so a corrupt tag can never wedge the multiplier.
  assign lane_free = ~rsp_val_q | i_rsp_rdy;
  assign id_ok     = |hit;
  assign o_mul_rdy = ~id_ok | (|(hit & lane_free));
  assign ret       = i_mul_val & o_mul_rdy;
  assign rsp_ld    = hit & {NUM_REQ{ret}};
  assign rsp_val_d = rsp_ld | (rsp_val_q & ~i_rsp_rdy);

  always_comb begin
    cred_d = cred_q;
    ovf    = 1'b0;
    case ({accept, ret})
      2'b10: cred_d = cred_q - CRED_W'(1);
      2'b01: begin
        if (cred_q == CRED_W'(MAX_OUTSTANDING)) ovf = 1'b1;
        else                                     cred_d = cred_q + CRED_W'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  assign err_d = err_q | (ret & ~id_ok) | ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mul_val_q <= 1'b0;
      rsp_val_q <= '0;
      cred_q    <= CRED_W'(MAX_OUTSTANDING);
      err_q     <= 1'b0;
    end else begin
      mul_val_q <= mul_val_d;
      rsp_val_q <= rsp_val_d;
      cred_q    <= cred_d;
      err_q     <= err_d;
    end
  end

  // Payload registers carry no reset; their valids gate them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mul_dat_q <= sel_dat;
      mul_tag_q <= sel_tag;
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rsp_ld[r]) begin
        rsp_dat_q[r] <= i_mul_dat;
        rsp_ctl_q[r] <= i_mul_ctl[CTL_BITS-1:0];
      end
    end
  end

  assign o_mul_val = mul_val_q;
  assign o_mul_dat = mul_dat_q;
  assign o_mul_ctl = mul_tag_q;
  assign o_rsp_val = rsp_val_q;
  assign o_rsp_dat = rsp_dat_q;
  assign o_rsp_ctl = rsp_ctl_q;
  assign o_credits = cred_q;
  assign o_err_id  = err_q;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench: stub multiplier returns a*b after a fixed delay; NUM_REQ=5 so id 5 is out of range.
module tb_mont_mul_arbiter;

  localparam int N  = 5;
  localparam int DB = 381;
  localparam int CB = 8;
  localparam int IB = 3;
  localparam int MO = 16;
  localparam int CW = 5;
  localparam int TW = CB + IB;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [N-1:0]            i_req_val;
  logic [N-1:0][2*DB-1:0]  i_req_dat;
  logic [N-1:0][CB-1:0]    i_req_ctl;
  logic [N-1:0]            o_req_rdy;
  logic                    o_mul_val;
  logic [2*DB-1:0]         o_mul_dat;
  logic [TW-1:0]           o_mul_ctl;
  logic                    i_mul_rdy;
  logic                    i_mul_val = 1'b0;
  logic [DB-1:0]           i_mul_dat = '0;
  logic [TW-1:0]           i_mul_ctl = '0;
  logic                    o_mul_rdy;
  logic [N-1:0]            o_rsp_val;
  logic [N-1:0][DB-1:0]    o_rsp_dat;
  logic [N-1:0][CB-1:0]    o_rsp_ctl;
  logic [N-1:0]            i_rsp_rdy;
  logic [CW-1:0]           o_credits;
  logic                    o_err_id;

  mont_mul_arbiter #(.NUM_REQ(N), .DAT_BITS(DB), .CTL_BITS(CB), .MAX_OUTSTANDING(MO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_val(i_req_val), .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .o_req_rdy(o_req_rdy),
    .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .i_mul_rdy(i_mul_rdy),
    .i_mul_val(i_mul_val), .i_mul_dat(i_mul_dat), .i_mul_ctl(i_mul_ctl), .o_mul_rdy(o_mul_rdy),
    .o_rsp_val(o_rsp_val), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .i_rsp_rdy(i_rsp_rdy),
    .o_credits(o_credits), .o_err_id(o_err_id)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int acc_cnt[N];
  int rsp_cnt[N];
  int glog[$];

  initial for (int r = 0; r < N; r++) begin acc_cnt[r] = 0; rsp_cnt[r] = 0; end

  always @(posedge i_clk) begin
    if (!i_rst) begin
      for (int r = 0; r < N; r++) begin
        if (i_req_val[r] && o_req_rdy[r]) begin acc_cnt[r]++; glog.push_back(r); end
        if (o_rsp_val[r] && i_rsp_rdy[r]) rsp_cnt[r]++;
      end
    end
  end

  // ---------------- stub multiplier ----------------
  typedef struct {
    logic [DB-1:0] dat;
    logic [TW-1:0] ctl;
    int            t;
  } ent_t;

  ent_t sq[$];
  int   cyc       = 0;
  int   ret_total = 0;
  int   ret_limit = 0;
  bit   stub_hold = 1'b0;

  always @(posedge i_clk) begin
    ent_t          e;
    logic [DB-1:0] pa, pb;
    cyc++;
    if (i_rst) sq.delete();
    else begin
      if (i_mul_val && o_mul_rdy) begin void'(sq.pop_front()); ret_total++; end
      if (o_mul_val && i_mul_rdy) begin
        pa    = o_mul_dat[DB-1:0];
        pb    = o_mul_dat[2*DB-1:DB];
        e.dat = pa * pb;
        e.ctl = o_mul_ctl;
        if (o_mul_ctl[CB-1:0] == 8'hEE) e.ctl[CB +: IB] = 3'd5;
        e.t   = cyc + 5;
        sq.push_back(e);
      end
    end
    #2;
    if (sq.size() > 0 && sq[0].t <= cyc && (!stub_hold || ret_total < ret_limit)) begin
      i_mul_val = 1'b1;
      i_mul_dat = sq[0].dat;
      i_mul_ctl = sq[0].ctl;
    end else begin
      i_mul_val = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic setreq(input int r, input logic [DB-1:0] a, input logic [DB-1:0] b, input logic [CB-1:0] c);
    i_req_dat[r] = {b, a};
    i_req_ctl[r] = c;
  endtask

  task automatic wait_rsp(input int r, input int lim);
    for (int i = 0; i < lim && !o_rsp_val[r]; i++) @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    int a0[N];
    int r0[N];
    i_rst = 1'b1; i_req_val = '0; i_req_dat = '0; i_req_ctl = '0;
    i_mul_rdy = 1'b1; i_rsp_rdy = '1;
    step(3);
    chk("rst_mul_val", o_mul_val, 0);
    chk("rst_rsp_val", o_rsp_val, 0);
    chk("rst_req_rdy", o_req_rdy, 0);
    chk("rst_credits", o_credits, 16);
    chk("rst_err", o_err_id, 0);
    i_rst = 1'b0;

    // single op: 3*5
    setreq(0, 3, 5, 8'h5A); i_req_val = 5'b00001; #1;
    chk("t1_rdy", o_req_rdy, 5'b00001);
    step(1); i_req_val = '0; #1;
    chk("t1_mul_val", o_mul_val, 1);
    chk("t1_mul_dat", o_mul_dat, {381'd5, 381'd3});
    chk("t1_mul_ctl", o_mul_ctl, 11'h05A);
    chk("t1_cred_dec", o_credits, 15);
    wait_rsp(0, 20);
    chk("t1_rsp_val", o_rsp_val[0], 1);
    chk("t1_rsp_dat", o_rsp_dat[0], 15);
    chk("t1_rsp_ctl", o_rsp_ctl[0], 8'h5A);
    chk("t1_cred_back", o_credits, 16);

    // round robin over 4 active requesters from pointer 0
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    for (int r = 0; r < 4; r++) setreq(r, DB'(r + 2), 10, CB'(8'h10 + r));
    for (int r = 0; r < N; r++) begin a0[r] = acc_cnt[r]; r0[r] = rsp_cnt[r]; end
    L = glog.size();
    i_req_val = 5'b01111;
    for (int i = 0; i < 40 && glog.size() < L + 12; i++) step(1);
    i_req_val = '0;
    chk("t2_accepts", glog.size() - L, 12);
    for (int k = 0; k < 12; k++) chk($sformatf("t2_order%0d", k), glog[L + k], k % 4);
    for (int r = 0; r < 4; r++) chk($sformatf("t2_share%0d", r), acc_cnt[r] - a0[r], 3);
    step(20);
    chk("t2_cred", o_credits, 16);
    for (int r = 0; r < 4; r++) chk($sformatf("t2_rsp%0d", r), rsp_cnt[r] - r0[r], 3);

    // credit exhaustion with multiplier holding results
    for (int r = 0; r < N; r++) begin a0[r] = acc_cnt[r]; r0[r] = rsp_cnt[r]; end
    ret_limit = ret_total; stub_hold = 1'b1;
    setreq(1, 7, 7, 8'h31); i_req_val = 5'b00010;
    step(20);
    chk("t3_acc16", acc_cnt[1] - a0[1], 16);
    chk("t3_rdy0", o_req_rdy, 0);
    chk("t3_cred0", o_credits, 0);
    ret_limit = ret_total + 1;
    step(4);
    chk("t3_acc17", acc_cnt[1] - a0[1], 17);
    chk("t3_cred0b", o_credits, 0);
    chk("t3_rdy0b", o_req_rdy, 0);
    i_req_val = '0; stub_hold = 1'b0;
    step(40);
    chk("t3_cred_end", o_credits, 16);
    chk("t3_rsp17", rsp_cnt[1] - r0[1], 17);

    // head-of-line blocking on a stalled requester
    i_rsp_rdy[2] = 1'b0;
    setreq(2, 2, 3, 8'h21); i_req_val = 5'b00100; #1;
    chk("t4_rdy_a", o_req_rdy, 5'b00100);
    step(1); setreq(2, 4, 5, 8'h22); #1;
    chk("t4_rdy_b", o_req_rdy, 5'b00100);
    step(1); setreq(0, 6, 7, 8'h01); i_req_val = 5'b00001; #1;
    chk("t4_rdy_c", o_req_rdy, 5'b00001);
    step(1); i_req_val = '0;
    step(12);
    chk("t4_hold_val", o_rsp_val[2], 1);
    chk("t4_hold_dat", o_rsp_dat[2], 6);
    chk("t4_mul_rdy", o_mul_rdy, 0);
    chk("t4_r0_wait", o_rsp_val[0], 0);
    chk("t4_cred", o_credits, 14);
    i_rsp_rdy[2] = 1'b1;
    step(1);
    chk("t4_second_val", o_rsp_val[2], 1);
    chk("t4_second_dat", o_rsp_dat[2], 20);
    chk("t4_second_ctl", o_rsp_ctl[2], 8'h22);
    chk("t4_r0_still", o_rsp_val[0], 0);
    step(1);
    chk("t4_r0_val", o_rsp_val[0], 1);
    chk("t4_r0_dat", o_rsp_dat[0], 42);
    chk("t4_r0_ctl", o_rsp_ctl[0], 8'h01);
    chk("t4_r2_done", o_rsp_val[2], 0);

    // out-of-range id on return
    setreq(3, 9, 9, 8'hEE); i_req_val = 5'b01000; #1;
    chk("t5_rdy", o_req_rdy, 5'b01000);
    step(1); i_req_val = '0;
    r0[3] = rsp_cnt[3];
    step(12);
    chk("t5_err", o_err_id, 1);
    chk("t5_rsp_none", o_rsp_val, 0);
    chk("t5_cred", o_credits, 16);
    chk("t5_rsp_cnt", rsp_cnt[3] - r0[3], 0);
    step(5);
    chk("t5_err_sticky", o_err_id, 1);

    // reset with work in flight
    for (int r = 0; r < 4; r++) setreq(r, DB'(20 + r), 2, CB'(8'h60 + r));
    L = glog.size();
    i_req_val = 5'b01111;
    step(5);
    chk("t6_inflight", glog.size() - L, 5);
    i_rst = 1'b1; i_req_val = '0;
    step(1);
    chk("t6_mul_val", o_mul_val, 0);
    chk("t6_rsp_val", o_rsp_val, 0);
    chk("t6_cred", o_credits, 16);
    chk("t6_err_clr", o_err_id, 0);
    i_rst = 1'b0;
    setreq(0, 11, 13, 8'h77); i_req_val = 5'b01111; #1;
    chk("t6_ptr0", o_req_rdy, 5'b00001);
    for (int r = 0; r < N; r++) r0[r] = rsp_cnt[r];
    step(1); i_req_val = '0;
    wait_rsp(0, 20);
    chk("t6_rsp_val", o_rsp_val[0], 1);
    chk("t6_rsp_dat", o_rsp_dat[0], 143);
    chk("t6_rsp_ctl", o_rsp_ctl[0], 8'h77);
    step(10);
    chk("t6_only_one", rsp_cnt[0] - r0[0], 1);
    chk("t6_no_stale", (rsp_cnt[1] - r0[1]) + (rsp_cnt[2] - r0[2]) + (rsp_cnt[3] - r0[3]), 0);
    chk("t6_cred_end", o_credits, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
